i2s_dac_receiver: RTL

- Codec-side deserializer for the DAC serial stream. It takes the BCLK/DACLRCK/DACDAT triple that the codec interface drives and recovers the 16-bit left and right samples as parallel words.
- Used as an on-chip loopback monitor: it checks the recorder's playback path bit-exactly against audio_output/audio_in without the SSM2603 in the loop.
- Runs entirely in the audio_clk domain. BCLK and LRCK are oversampled, never used as clocks.

---
 rtl/i2s_dac_receiver_pkg.sv | 9 +
 rtl/i2s_dac_receiver_if.sv | 8 +
 rtl/i2s_dac_receiver_sync_edge_detect.sv | 23 ++
 rtl/i2s_dac_receiver.sv | 71 +++++++
 4 files changed

// File: rtl/i2s_dac_receiver_pkg.sv
// i2s_dac_receiver_pkg: shared FSM encoding, channel indices and default word width
package i2s_dac_receiver_pkg;
  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int CH_LEFT = 0;
  localparam int CH_RIGHT = 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
endpackage

// File: rtl/i2s_dac_receiver_if.sv
// i2s_dac_receiver_if: DAC serial triple (bclk bit clock, lrck word select, sdata serial data)
interface i2s_dac_receiver_if;
  logic bclk;
  logic lrck;
  logic sdata;
  modport master (output bclk, lrck, sdata);
  modport slave (input bclk, lrck, sdata);
endinterface

// File: rtl/i2s_dac_receiver_sync_edge_detect.sv
// i2s_dac_receiver_sync_edge_detect: STAGES-flop synchronizer; ports clk, reset (async active-low), d in, q synced out, rise one-clk pulse on q 0->1
module i2s_dac_receiver_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);
  logic [STAGES-1:0] s;
  logic p;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s <= '0;
      p <= 1'b0;
    end else begin
      s <= STAGES'({s, d});
      p <= s[STAGES-1];
    end
  assign q = s[STAGES-1];
  assign rise = q & ~p;
endmodule

// File: rtl/i2s_dac_receiver.sv
// i2s_dac_receiver: oversampling DAC-stream deserializer; ports clk, reset (async active-low), enable, bus (bclk/lrck/sdata), clear_error, left_sample, right_sample, sample_valid (bit0 left, bit1 right), frame_error (sticky)
module i2s_dac_receiver
  import i2s_dac_receiver_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int I2S_DELAY = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  i2s_dac_receiver_if.slave       bus,
  input  logic                    clear_error,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic [1:0]              sample_valid,
  output logic                    frame_error
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  logic bclk_s, rise, lrck_s, sdata_s, lrck_rise_unused, sdata_rise_unused;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [SAMPLE_WIDTH-1:0] sh, sh_next;
  logic ch, last_lrck, boundary;
  i2s_dac_receiver_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk(clk), .reset(reset), .d(bus.bclk), .q(bclk_s), .rise(rise));
  i2s_dac_receiver_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk(clk), .reset(reset), .d(bus.lrck), .q(lrck_s), .rise(lrck_rise_unused));
  i2s_dac_receiver_sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sdata (
    .clk(clk), .reset(reset), .d(bus.sdata), .q(sdata_s), .rise(sdata_rise_unused));
  always_comb begin
    boundary = rise && bclk_s && (lrck_s != last_lrck);
    sh_next = {sh[SAMPLE_WIDTH-2:0], sdata_s};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      left_sample <= '0;
      right_sample <= '0;
      sample_valid <= 2'b00;
      frame_error <= 1'b0;
      state <= ST_IDLE;
      cnt <= '0;
      sh <= '0;
      ch <= 1'b0;
      last_lrck <= 1'b0;
    end else begin
      sample_valid <= 2'b00;
      if (rise) last_lrck <= lrck_s;
      if (clear_error) frame_error <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        cnt <= '0;
      end else if (boundary) begin
        // SHIFT always holds a partial word, so a boundary there is a short frame
        if (state == ST_SHIFT) frame_error <= 1'b1;
        state <= ST_SHIFT;
        ch <= lrck_s;
        sh <= SAMPLE_WIDTH'(I2S_DELAY != 0 ? 1'b0 : sdata_s);
        cnt <= CW'(I2S_DELAY == 0);
      end else if (rise && state == ST_SHIFT) begin
        sh <= sh_next;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(SAMPLE_WIDTH - 1)) begin
          state <= ST_WAIT;
          sample_valid[ch ? CH_RIGHT : CH_LEFT] <= 1'b1;
          if (ch) right_sample <= sh_next;
          else left_sample <= sh_next;
        end
      end
    end
endmodule
